// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..P-1 and pulses bit_done on the last count.
// A zero period is treated as one cycle so the line can never stall.
module bit_timer #(
   parameter int COUNTER_WIDTH = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [COUNTER_WIDTH-1:0] period,
   output logic                     bit_done
);

   logic [COUNTER_WIDTH-1:0] cnt_q;
   logic [COUNTER_WIDTH-1:0] cnt_d;
   logic [COUNTER_WIDTH-1:0] last_cnt;

   always_comb begin
      last_cnt = (period == '0) ? '0 : period - COUNTER_WIDTH'(1);
      bit_done = (cnt_q == last_cnt);
      cnt_d    = cnt_q + COUNTER_WIDTH'(1);
      if (clear || bit_done) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register in front of the
// shift register so consecutive bytes leave back-to-back.
//
// state | meaning
// IDLE  | line high, waiting for a full holding register
// START | start bit (0) for one period
// DATA  | shift[0] for one period, eight times, LSB first
// STOP  | stop bit (1); chains straight into START if a byte is waiting
module uart_tx
   import uart_pkg::*;
#(
   parameter int COUNTER_WIDTH = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               data,
   input  logic                     data_valid,
   output logic                     data_ready,
   input  logic [COUNTER_WIDTH-1:0] cycles_per_bit,
   output logic                     uart_tx_out,
   output logic                     busy
);

   localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

   uart_tx_state_t           state_q, state_d;
   logic                     hold_full_q, hold_full_d;
   logic [7:0]               hold_data_q, hold_data_d;
   logic [7:0]               shift_q, shift_d;
   logic [2:0]               idx_q, idx_d;
   logic [COUNTER_WIDTH-1:0] period_q, period_d;
   logic                     tx_q, tx_d;
   logic                     transfer;
   logic                     load;
   logic                     timer_clear;
   logic                     bit_done;

   bit_timer #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
   ) u_bit_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (timer_clear),
      .period   (period_q),
      .bit_done (bit_done)
   );

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      period_d = period_q;
      transfer = 1'b0;

      case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               transfer = 1'b1;
               state_d  = START;
            end
         end
         START: begin
            if (bit_done) begin
               idx_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == LAST_IDX) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (bit_done) begin
               if (hold_full_q) begin
                  transfer = 1'b1;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The period is captured only here, so mid-frame changes wait for the next frame.
      if (transfer) begin
         shift_d  = hold_data_q;
         period_d = cycles_per_bit;
      end

      load        = data_valid && !hold_full_q;
      hold_full_d = load || (hold_full_q && !transfer);
      hold_data_d = load ? data : hold_data_q;

      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         default: tx_d = UART_IDLE_LEVEL;
      endcase

      timer_clear = (state_q == IDLE) || (state_d != state_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         shift_q     <= '0;
         idx_q       <= '0;
         period_q    <= '0;
         tx_q        <= UART_IDLE_LEVEL;
      end else begin
         state_q     <= state_d;
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         period_q    <= period_d;
         tx_q        <= tx_d;
      end
   end

   assign data_ready  = !hold_full_q;
   assign busy        = (state_q != IDLE);
   assign uart_tx_out = tx_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter, 8N1, LSB first, idle-high line. Companion to the design's UART receiver: it takes its bit period in clock cycles from a `cycles_per_bit` input, normally the receiver's measured value, so replies go out at the host's auto-detected baud rate. A one-byte holding register decouples the valid/ready byte interface from the shift register, so consecutive bytes go out back-to-back with no idle gap.

## Interface
- `COUNTER_WIDTH`, default 24: width of the bit-period input and the internal bit timer.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data`  in  8  byte to send; sampled on a valid/ready handshake.
- `data_valid`  in  1  a byte is offered on `data`.
- `data_ready`  out  1  holding register empty; the byte is accepted when `data_valid && data_ready` at a rising edge.
- `cycles_per_bit`  in  COUNTER_WIDTH  bit period in clock cycles; 0 is treated as 1.
- `uart_tx_out`  out  1  serial line, registered.
- `busy`  out  1  a frame is in progress (state other than IDLE).

## Operation
- Reset values: `uart_tx_out`=1, `data_ready`=1, `busy`=0, state=IDLE, holding register empty, timer=0.
- Holding register:
  - Loaded on handshake; `data_ready` deasserts the next cycle.
  - Emptied when the FSM moves its contents into the shift register; `data_ready` reasserts the next cycle.
  - Load and unload in the same cycle are both honoured, so the register stays full with the new byte.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_tx_out`=1. When the holding register is full, transfer it to the shift register, latch `cycles_per_bit` into the period register, and go to START.
  - START: drive 0 for one bit period, then go to DATA with bit index 0.
  - DATA: drive `shift[0]` for one period. At period end, shift right and increment the index. After index 7, go to STOP.
  - STOP: drive 1 for one period. At period end:
    - if the holding register is full, do the transfer and period latch as in IDLE and go directly to START;
    - otherwise go to IDLE.
- Bit timer:
  - Counts 0 to P-1, where P = max(latched period, 1).
  - `bit_done` pulses on the count P-1; the timer clears to 0 on `bit_done` and on every state entry.
  - Counter width is COUNTER_WIDTH; no wrap is possible because P ≤ 2^COUNTER_WIDTH−1.
- `cycles_per_bit` is sampled only at frame start. Changes mid-frame take effect on the next frame.
- `data` is don't-care when there is no handshake. A `data_valid` with `data_ready`=0 is ignored, and the sender must hold it.

## Timing
- Handshake at edge N while IDLE: the FSM enters START at N+1, and `uart_tx_out` falls at N+2 (output registered from the state).
- Each bit lasts exactly P cycles. A full frame is 10·P cycles from the falling edge to the end of the stop bit.
- Back-to-back: if the next byte is in the holding register before the end of STOP, the next start bit begins on the cycle right after the stop bit's last cycle. There is zero idle time.
- `data_ready` returns high one cycle after transfer, so a second byte can be accepted during the first frame's start bit.
- `busy` rises with START entry and falls on return to IDLE. It stays high across back-to-back frames.
- Reset asserted mid-frame:
  - `uart_tx_out` goes to 1 immediately (asynchronously); the partial frame and any held byte are discarded.
  - The first frame after reset release begins no earlier than 2 cycles after the first handshake.

## Structure
- Shared package `uart_pkg`:
  - `uart_tx_state_t` (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS` = 8;
  - `UART_IDLE_LEVEL` = 1'b1.
- One sub-module, `bit_timer` (parameter COUNTER_WIDTH; ports `clk`, `rst_n`, `clear`, `period`, `bit_done`). It implements the P-cycle counter and saturates a zero period to 1.
- Top level: FSM, holding register, shift register and bit index.

## Test plan
- Single byte, `cycles_per_bit`=16, send 0x55 → line low at handshake+2, then bits 1,0,1,0,1,0,1,0 (LSB first), then stop=1. Each level lasts 16 cycles; `busy` high for 160 cycles.
- Back-to-back 0xA3 then 0x0F, `cycles_per_bit`=8, second byte offered during the first frame's start bit → second start bit starts exactly 80 cycles after the first. No idle cycle between frames; `data_ready` low only while the holding register is full.
- Period edge cases: `cycles_per_bit`=0 and =1 → each bit lasts 1 cycle. `cycles_per_bit` changed from 12 to 20 mid-frame → current frame keeps 12-cycle bits, next frame uses 20.
- Backpressure: hold `data_valid` with 0x11, 0x22, 0x33 continuously → exactly three frames with data 0x11, 0x22, 0x33 in order. No byte is lost or duplicated.
- Reset mid-frame: assert `rst_n`=0 during bit D3 of 0xFF → `uart_tx_out`=1 in the same cycle, `data_ready`=1, `busy`=0. After release, send 0x80 → one clean frame.
- Loopback through the design's UART receiver: random bytes at `cycles_per_bit` values 10, 87 and 1000 → every byte received intact, and the receiver's measured period matches within ±1 cycle.
